mem_bus_arbiter: RTL and testbench

- Owns the SM83 external memory bus and shares it between the CPU memory port and an internal OAM DMA engine.
- Decodes CPU accesses:
  - FF00-FFFF goes to the high (IO/HRAM) port.
  - FF46 is intercepted locally as the DMA register.
  - Everything else goes to the main bus.
- While DMA is running, main-bus CPU accesses are blocked and the engine copies 160 bytes from {src_hi,00} to OAM.
- One clk = one M-cycle.

---
 rtl/sm83_pkg.sv | 19 +
 rtl/oam_dma_engine.sv | 113 +++++++++++
 rtl/mem_bus_arbiter.sv | 98 +++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 bus definitions: OAM DMA state encoding and fixed address map points.
package sm83_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER,
        DMA_FLUSH
    } dma_state_t;

    localparam logic [15:0] ADDR_DMA_REG   = 16'hFF46;
    localparam logic [15:0] HI_REGION_BASE = 16'hFF00;
    localparam logic [15:0] OAM_BASE       = 16'hFE00;

    function automatic logic is_hi_region(input logic [15:0] addr);
        return addr >= HI_REGION_BASE;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: FF46 register, transfer FSM, index counter and the one-deep
// registered OAM write pipeline.
module oam_dma_engine
    import sm83_pkg::*;
#(
    parameter int OAM_LEN     = 160,
    parameter int START_DELAY = 1,
    parameter int ECHO_FOLD   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  dma_reg,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    output logic        active,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);
    localparam logic [7:0] LAST_DLY = 8'(START_DELAY - 1);

    dma_state_t state_reg, state_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] dly_reg, dly_next;
    logic [7:0] dma_val_reg;
    logic       wr_valid_reg;
    logic [7:0] wr_addr_reg;
    logic [7:0] wr_data_reg;
    logic [7:0] src_hi;

    // Echo RAM (E000-FFFF) mirrors C000-DFFF, so DMA sources there read the mirror.
    generate
        if (ECHO_FOLD != 0) begin : g_fold
            assign src_hi = (dma_val_reg >= 8'hE0) ? (dma_val_reg - 8'h20) : dma_val_reg;
        end else begin : g_nofold
            assign src_hi = dma_val_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dly_next   = dly_reg;
        rd_en      = 1'b0;
        case (state_reg)
            DMA_IDLE: begin
            end
            DMA_START: begin
                if (dly_reg == LAST_DLY) begin
                    state_next = DMA_XFER;
                    idx_next   = 8'd0;
                end else begin
                    dly_next = dly_reg + 8'd1;
                end
            end
            DMA_XFER: begin
                rd_en = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = DMA_FLUSH;
                end else begin
                    idx_next = idx_reg + 8'd1;
                end
            end
            DMA_FLUSH: begin
                state_next = DMA_IDLE;
            end
            default: state_next = DMA_IDLE;
        endcase
        // A register write restarts from any state; the read issued this cycle still lands.
        if (reg_wr) begin
            state_next = (START_DELAY == 0) ? DMA_XFER : DMA_START;
            idx_next   = 8'd0;
            dly_next   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DMA_IDLE;
            idx_reg      <= 8'd0;
            dly_reg      <= 8'd0;
            dma_val_reg  <= 8'hFF;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= 8'd0;
            wr_data_reg  <= 8'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            dly_reg      <= dly_next;
            wr_valid_reg <= rd_en;
            if (reg_wr) begin
                dma_val_reg <= reg_wdata;
            end
            if (rd_en) begin
                wr_addr_reg <= idx_reg;
                wr_data_reg <= bus_rdata;
            end
        end
    end

    assign dma_reg   = dma_val_reg;
    assign rd_addr   = {src_hi, idx_reg};
    assign active    = (state_reg == DMA_XFER) || (state_reg == DMA_FLUSH);
    assign oam_addr  = wr_addr_reg;
    assign oam_wdata = wr_data_reg;
    assign oam_we    = wr_valid_reg & ~rst;

endmodule

// File: rtl/mem_bus_arbiter.sv
// SM83 external bus owner: decodes CPU accesses into main bus / high region / FF46
// and hands the main bus to the OAM DMA engine while a transfer is running.
module mem_bus_arbiter
    import sm83_pkg::*;
#(
    parameter int OAM_LEN     = 160,
    parameter int START_DELAY = 1,
    parameter int ECHO_FOLD   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  hi_addr,
    output logic        hi_rd,
    output logic        hi_wr,
    output logic [7:0]  hi_wdata,
    input  logic [7:0]  hi_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    logic        sel_dma_reg;
    logic        sel_hi;
    logic        sel_main;
    logic        dma_reg_wr;
    logic [7:0]  dma_reg;
    logic        dma_rd_en;
    logic [15:0] dma_rd_addr;

    assign sel_dma_reg = (cpu_addr == ADDR_DMA_REG);
    assign sel_hi      = is_hi_region(cpu_addr) && !sel_dma_reg;
    assign sel_main    = !is_hi_region(cpu_addr);
    assign dma_reg_wr  = cpu_wr && sel_dma_reg && !rst;

    oam_dma_engine #(
        .OAM_LEN     (OAM_LEN),
        .START_DELAY (START_DELAY),
        .ECHO_FOLD   (ECHO_FOLD)
    ) u_dma (
        .clk       (clk),
        .rst       (rst),
        .reg_wr    (dma_reg_wr),
        .reg_wdata (cpu_wdata),
        .bus_rdata (bus_rdata),
        .dma_reg   (dma_reg),
        .rd_en     (dma_rd_en),
        .rd_addr   (dma_rd_addr),
        .active    (dma_active),
        .oam_addr  (oam_addr),
        .oam_we    (oam_we),
        .oam_wdata (oam_wdata)
    );

    always_comb begin
        bus_addr  = 16'h0000;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_wdata = 8'h00;
        if (dma_active) begin
            // FLUSH leaves the bus undriven; only XFER asserts a read.
            bus_addr = dma_rd_en ? dma_rd_addr : 16'h0000;
            bus_rd   = dma_rd_en && !rst;
        end else if (sel_main) begin
            bus_addr  = cpu_addr;
            bus_rd    = cpu_rd && !rst;
            bus_wr    = cpu_wr && !rst;
            bus_wdata = cpu_wdata;
        end
    end

    assign hi_addr  = cpu_addr[7:0];
    assign hi_rd    = cpu_rd && sel_hi && !rst;
    assign hi_wr    = cpu_wr && sel_hi && !rst;
    assign hi_wdata = cpu_wdata;

    always_comb begin
        cpu_rdata = 8'hFF;
        if (sel_dma_reg) begin
            cpu_rdata = dma_reg;
        end else if (sel_hi) begin
            cpu_rdata = hi_rdata;
        end else if (!dma_active) begin
            cpu_rdata = bus_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scripted DMA scenarios, OAM writes scored against a
// queue of expected (index, byte) pairs pushed when FF46 is written.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  hi_addr;
    logic        hi_rd;
    logic        hi_wr;
    logic [7:0]  hi_wdata;
    logic [7:0]  hi_rdata;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } oam_exp_t;

    oam_exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .hi_addr    (hi_addr),
        .hi_rd      (hi_rd),
        .hi_wr      (hi_wr),
        .hi_wdata   (hi_wdata),
        .hi_rdata   (hi_rdata),
        .oam_addr   (oam_addr),
        .oam_we     (oam_we),
        .oam_wdata  (oam_wdata),
        .dma_active (dma_active)
    );

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign bus_rdata = mem_model(bus_addr);
    assign hi_rdata  = hi_addr ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_addr  = 16'h0000;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = 8'h00;
    endtask

    // Drive an FF46 write in the current cycle and queue the 160 OAM writes it implies.
    task automatic write_dma(input logic [7:0] val);
        logic [7:0] src;
        cpu_addr  = 16'hFF46;
        cpu_wr    = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wdata = val;
        #1;
        check("ff46_no_hi_wr", hi_wr, 1'b0);
        src = (val >= 8'hE0) ? val - 8'h20 : val;
        for (int i = 0; i < 160; i++) begin
            sb_q.push_back('{addr: 8'(i), data: mem_model({src, 8'(i)})});
        end
        $display("txn: FF46 <= 0x%02h (src 0x%02h00)", val, src);
    endtask

    // Cycles 1..ncyc after an FF46 write: DMA read address and dma_active timing.
    task automatic run_xfer(input logic [7:0] src, input int ncyc, input bit cpu_probe);
        for (int t = 1; t <= ncyc; t++) begin
            cycle();
            idle_inputs();
            if (t == 1 || t == 163) begin
                check("dma_active_off", dma_active, 1'b0);
            end else begin
                check("dma_active_on", dma_active, 1'b1);
            end
            if (t >= 2 && t <= 161) begin
                check("dma_bus_rd", bus_rd, 1'b1);
                check("dma_bus_addr", bus_addr, {src, 8'(t - 2)});
            end else begin
                check("dma_bus_rd_idle", bus_rd, 1'b0);
            end
            if (cpu_probe && t == 10) begin
                cpu_addr = 16'hC000; cpu_rd = 1'b1; #1;
                check("blk_rd_data", cpu_rdata, 8'hFF);
                check("blk_rd_addr", bus_addr, {src, 8'(t - 2)});
                $display("txn: CPU rd C000 during DMA -> 0x%02h", cpu_rdata);
            end
            if (cpu_probe && t == 11) begin
                cpu_addr = 16'h8000; cpu_wr = 1'b1; cpu_wdata = 8'h77; #1;
                check("blk_wr_strobe", bus_wr, 1'b0);
                $display("txn: CPU wr 8000 during DMA dropped");
            end
            if (cpu_probe && t == 12) begin
                cpu_addr = 16'hFF80; cpu_rd = 1'b1; #1;
                check("hi_rd", hi_rd, 1'b1);
                check("hi_addr", hi_addr, 8'h80);
                check("hi_rdata", cpu_rdata, 8'h80 ^ 8'hA5);
                $display("txn: CPU rd FF80 during DMA -> 0x%02h", cpu_rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        if (oam_we) begin
            if (sb_q.size() == 0) begin
                check("oam_unexpected", 1'b1, 1'b0);
            end else begin
                oam_exp_t e;
                e = sb_q.pop_front();
                check("oam_addr", oam_addr, e.addr);
                check("oam_wdata", oam_wdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        check("rst_oam_we", oam_we, 1'b0);
        check("rst_bus_rd", bus_rd, 1'b0);
        rst = 1'b0;
        cycle();
        check("rst_dma_active", dma_active, 1'b0);
        cpu_addr = 16'hFF46; cpu_rd = 1'b1; #1;
        check("rst_dma_reg", cpu_rdata, 8'hFF);

        // Plain transfer from C100 with CPU probes.
        write_dma(8'hC1);
        run_xfer(8'hC1, 163, 1'b1);
        check("sb_empty_c1", sb_q.size(), 0);

        // Echo fold: F0 reads D000..
        write_dma(8'hF0);
        run_xfer(8'hD0, 163, 1'b0);
        check("sb_empty_f0", sb_q.size(), 0);

        // Restart while idx 50 is being read.
        write_dma(8'hD0);
        run_xfer(8'hD0, 52, 1'b0);
        while (sb_q.size() > 0 && sb_q[$].addr > 8'd50) begin
            void'(sb_q.pop_back());
        end
        write_dma(8'hD0);
        run_xfer(8'hD0, 163, 1'b0);
        check("sb_empty_restart", sb_q.size(), 0);

        // No DMA: straight-through main bus write and FF46 readback.
        cpu_addr = 16'hC123; cpu_wr = 1'b1; cpu_wdata = 8'h55; #1;
        check("pt_bus_wr", bus_wr, 1'b1);
        check("pt_bus_addr", bus_addr, 16'hC123);
        check("pt_bus_wdata", bus_wdata, 8'h55);
        $display("txn: CPU wr C123 <= 0x55 passthrough");
        cycle();
        idle_inputs();
        cpu_addr = 16'hFF46; cpu_rd = 1'b1; #1;
        check("ff46_readback", cpu_rdata, 8'hD0);
        check("ff46_no_hi_rd", hi_rd, 1'b0);
        $display("txn: CPU rd FF46 -> 0x%02h", cpu_rdata);
        cycle();
        idle_inputs();

        // Reset at idx 80, with a coincident FF46 write that must be ignored.
        write_dma(8'hC1);
        run_xfer(8'hC1, 82, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        cpu_addr = 16'hFF46; cpu_wr = 1'b1; cpu_wdata = 8'h12; #1;
        check("rstmid_bus_rd", bus_rd, 1'b0);
        check("rstmid_oam_we", oam_we, 1'b0);
        cycle();
        rst = 1'b0;
        idle_inputs();
        sb_q.delete();
        check("post_rst_oam_we", oam_we, 1'b0);
        check("post_rst_active", dma_active, 1'b0);
        cpu_addr = 16'hFF46; cpu_rd = 1'b1; #1;
        check("post_rst_dma_reg", cpu_rdata, 8'hFF);
        $display("txn: reset mid-DMA, FF46 -> 0x%02h", cpu_rdata);
        cycle();
        idle_inputs();
        check("post_rst_idle", dma_active, 1'b0);
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
